// File: rtl/keep_cnt_codec.sv
// -----------------------------------------------------------------------------
// keep_cnt_codec
//
// Byte-enable / byte-count codec for the 64-bit AXI-Stream transmit checksum
// datapath.  Two independent directions:
//   keep -> cnt : popcount of an 8-bit tkeep mask, with a contiguity check
//   cnt  -> keep: LSB-aligned keep mask from a byte count, saturating at 8
// Each direction offers a combinational result (no reset, no valid gating)
// and a registered result with a 1-cycle latency and a valid flag.
//
// Ports:
//   mm2s_clk        in   rising-edge clock for all registers
//   mm2s_reset      in   synchronous, active-high reset
//   keep_in_valid   in   qualifies keep_in
//   keep_in         in   tkeep mask, bit i = byte i valid
//   cnt_comb        out  combinational popcount of keep_in (0..8)
//   cnt_out         out  registered popcount, held when keep_in_valid = 0
//   cnt_out_valid   out  keep_in_valid delayed by one cycle
//   keep_err        out  registered: keep_in was not of the form (1<<n)-1
//   cnt_in_valid    in   qualifies cnt_in
//   cnt_in          in   byte count, unsigned 0..15
//   keep_comb       out  combinational mask with bits [cnt_in-1:0] set
//   keep_out        out  registered mask, held when cnt_in_valid = 0
//   keep_out_valid  out  cnt_in_valid delayed by one cycle
//   cnt_ovf         out  registered: cnt_in > 8 (mask saturated to all ones)
// -----------------------------------------------------------------------------
module keep_cnt_codec #(
   parameter int C_KEEP_WIDTH = 8,
   parameter int C_CNT_WIDTH  = 4
) (
   input  logic                    mm2s_clk,
   input  logic                    mm2s_reset,

   input  logic                    keep_in_valid,
   input  logic [C_KEEP_WIDTH-1:0] keep_in,
   output logic [C_CNT_WIDTH-1:0]  cnt_comb,
   output logic [C_CNT_WIDTH-1:0]  cnt_out,
   output logic                    cnt_out_valid,
   output logic                    keep_err,

   input  logic                    cnt_in_valid,
   input  logic [C_CNT_WIDTH-1:0]  cnt_in,
   output logic [C_KEEP_WIDTH-1:0] keep_comb,
   output logic [C_KEEP_WIDTH-1:0] keep_out,
   output logic                    keep_out_valid,
   output logic                    cnt_ovf
);

   // Only the 8-byte datapath is supported.
   generate
      if (C_KEEP_WIDTH != 8 || C_CNT_WIDTH != $clog2(C_KEEP_WIDTH + 1)) begin : g_bad_cfg
         $fatal(1, "keep_cnt_codec: unsupported C_KEEP_WIDTH/C_CNT_WIDTH");
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // keep -> cnt, combinational
   // ---------------------------------------------------------------------------
   logic [C_KEEP_WIDTH-1:0] keep_plus1;
   logic                    keep_legal;

   always_comb begin
      cnt_comb = '0;
      for (int unsigned i = 0; i < C_KEEP_WIDTH; i++) begin
         cnt_comb = cnt_comb + C_CNT_WIDTH'(keep_in[i]);
      end
   end

   // A mask of the form (1<<n)-1 has no set bit above a clear bit, so adding
   // one carries through all the ones and clears them: keep & (keep+1) == 0.
   // The all-ones mask wraps to zero, which also satisfies the test.
   assign keep_plus1 = keep_in + C_KEEP_WIDTH'(1);
   assign keep_legal = ((keep_in & keep_plus1) == '0);

   // ---------------------------------------------------------------------------
   // cnt -> keep, combinational
   // ---------------------------------------------------------------------------
   logic cnt_over;

   // Bit i is set when the count covers byte i; counts above 8 naturally
   // saturate to all ones.
   always_comb begin
      keep_comb = '0;
      for (int unsigned i = 0; i < C_KEEP_WIDTH; i++) begin
         keep_comb[i] = (32'(cnt_in) > i);
      end
   end

   assign cnt_over = (cnt_in > C_CNT_WIDTH'(C_KEEP_WIDTH));

   // ---------------------------------------------------------------------------
   // Registered results
   // ---------------------------------------------------------------------------
   always_ff @(posedge mm2s_clk) begin
      if (mm2s_reset) begin
         cnt_out        <= '0;
         keep_err       <= 1'b0;
         cnt_out_valid  <= 1'b0;
         keep_out       <= '0;
         cnt_ovf        <= 1'b0;
         keep_out_valid <= 1'b0;
      end else begin
         cnt_out_valid  <= keep_in_valid;
         keep_out_valid <= cnt_in_valid;
         if (keep_in_valid) begin
            cnt_out  <= cnt_comb;
            keep_err <= ~keep_legal;
         end
         if (cnt_in_valid) begin
            keep_out <= keep_comb;
            cnt_ovf  <= cnt_over;
         end
      end
   end

endmodule

// File: tb/tb_keep_cnt_codec.sv
// -----------------------------------------------------------------------------
// tb_keep_cnt_codec
//
// Scoreboard bench for keep_cnt_codec.  Stimulus pushes the expected
// registered response (with the cycle it must appear in) into a queue per
// direction; a monitor on the falling edge pops and compares whenever an
// output valid is high.  Combinational and hold/reset behaviour is checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_keep_cnt_codec;

   logic       clk = 1'b0;
   logic       rst;
   logic       keep_in_valid;
   logic [7:0] keep_in;
   logic [3:0] cnt_comb;
   logic [3:0] cnt_out;
   logic       cnt_out_valid;
   logic       keep_err;
   logic       cnt_in_valid;
   logic [3:0] cnt_in;
   logic [7:0] keep_comb;
   logic [7:0] keep_out;
   logic       keep_out_valid;
   logic       cnt_ovf;

   keep_cnt_codec #(.C_KEEP_WIDTH(8), .C_CNT_WIDTH(4)) dut (
      .mm2s_clk       (clk),
      .mm2s_reset     (rst),
      .keep_in_valid  (keep_in_valid),
      .keep_in        (keep_in),
      .cnt_comb       (cnt_comb),
      .cnt_out        (cnt_out),
      .cnt_out_valid  (cnt_out_valid),
      .keep_err       (keep_err),
      .cnt_in_valid   (cnt_in_valid),
      .cnt_in         (cnt_in),
      .keep_comb      (keep_comb),
      .keep_out       (keep_out),
      .keep_out_valid (keep_out_valid),
      .cnt_ovf        (cnt_ovf)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  cnt;
      logic        err;
   } cnt_exp_t;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  keep;
      logic        ovf;
   } keep_exp_t;

   cnt_exp_t  cnt_q[$];
   keep_exp_t keep_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Table-based reference models.
   function automatic logic legal_keep(input logic [7:0] k);
      case (k)
         8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] ref_keep(input int c);
      logic [7:0] tbl [0:8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                8'h1F, 8'h3F, 8'h7F, 8'hFF};
      return (c > 8) ? 8'hFF : tbl[c];
   endfunction

   // Monitor: registered outputs, sampled on the falling edge.
   always @(negedge clk) begin
      if (cnt_out_valid) begin
         if (cnt_q.size() == 0) begin
            chk("cnt_out_valid_unexpected", 32'(cnt_out_valid), 32'd0);
         end else begin
            cnt_exp_t e;
            e = cnt_q.pop_front();
            chk("cnt_out_cycle", cyc, e.cyc);
            chk("cnt_out", 32'(cnt_out), 32'(e.cnt));
            chk("keep_err", 32'(keep_err), 32'(e.err));
         end
      end
      if (keep_out_valid) begin
         if (keep_q.size() == 0) begin
            chk("keep_out_valid_unexpected", 32'(keep_out_valid), 32'd0);
         end else begin
            keep_exp_t e;
            e = keep_q.pop_front();
            chk("keep_out_cycle", cyc, e.cyc);
            chk("keep_out", 32'(keep_out), 32'(e.keep));
            chk("cnt_ovf", 32'(cnt_ovf), 32'(e.ovf));
         end
      end
   end

   // Drive one cycle of inputs just after a rising edge; they are sampled at
   // the next rising edge, so any result appears at cycle cyc+1.
   task automatic step(input logic r, input logic kv, input logic [7:0] k,
                       input logic cv, input logic [3:0] c);
      @(posedge clk);
      #1;
      rst           = r;
      keep_in_valid = kv;
      keep_in       = k;
      cnt_in_valid  = cv;
      cnt_in        = c;
      if (!r && kv) cnt_q.push_back('{cyc + 1, 4'($countones(k)), ~legal_keep(k)});
      if (!r && cv) keep_q.push_back('{cyc + 1, ref_keep(int'(c)), (c > 4'd8)});
      #1;
   endtask

   initial begin
      rst = 1'b1; keep_in_valid = 1'b0; keep_in = '0; cnt_in_valid = 1'b0; cnt_in = '0;

      // Reset state
      step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      chk("rst_cnt_out", 32'(cnt_out), 32'd0);
      chk("rst_keep_err", 32'(keep_err), 32'd0);
      chk("rst_cnt_out_valid", 32'(cnt_out_valid), 32'd0);
      chk("rst_keep_out", 32'(keep_out), 32'h00);
      chk("rst_cnt_ovf", 32'(cnt_ovf), 32'd0);
      chk("rst_keep_out_valid", 32'(keep_out_valid), 32'd0);

      // Exhaustive keep -> cnt
      for (int k = 0; k < 256; k++) begin
         step(1'b0, 1'b1, 8'(k), 1'b0, 4'd0);
         chk("cnt_comb", 32'(cnt_comb), 32'($countones(8'(k))));
      end

      // Exhaustive cnt -> keep, plus hand-picked points
      for (int c = 0; c < 16; c++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 4'(c));
         chk("keep_comb", 32'(keep_comb), 32'(ref_keep(c)));
         if (c == 0) chk("keep_comb_0", 32'(keep_comb), 32'h00);
         if (c == 3) chk("keep_comb_3", 32'(keep_comb), 32'h07);
         if (c == 8) chk("keep_comb_8", 32'(keep_comb), 32'hFF);
         if (c == 12) chk("keep_comb_12", 32'(keep_comb), 32'hFF);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);

      // Hold behaviour
      step(1'b0, 1'b1, 8'h0F, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'hFF, 1'b0, 4'd0);
         chk("hold_cnt_comb", 32'(cnt_comb), 32'd8);
         chk("hold_cnt_out", 32'(cnt_out), 32'd4);
         chk("hold_cnt_out_valid", 32'(cnt_out_valid), (i == 0) ? 32'd1 : 32'd0);
      end
      step(1'b0, 1'b0, 8'hFF, 1'b0, 4'd0);
      chk("hold_cnt_out_end", 32'(cnt_out), 32'd4);
      chk("hold_keep_out", 32'(keep_out), 32'hFF);

      // Concurrent directions
      step(1'b0, 1'b1, 8'h3F, 1'b1, 4'd5);
      step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      chk("conc_cnt_out", 32'(cnt_out), 32'd6);
      chk("conc_keep_out", 32'(keep_out), 32'h1F);
      chk("conc_valids", {30'd0, cnt_out_valid, keep_out_valid}, 32'd3);
      chk("conc_flags", {30'd0, keep_err, cnt_ovf}, 32'd0);

      // Reset priority over a valid input; comb outputs unaffected by reset
      step(1'b1, 1'b1, 8'hFF, 1'b1, 4'd3);
      chk("rst_comb_cnt", 32'(cnt_comb), 32'd8);
      chk("rst_comb_keep", 32'(keep_comb), 32'h07);
      step(1'b0, 1'b1, 8'h01, 1'b0, 4'd0);
      chk("rstp_cnt_out", 32'(cnt_out), 32'd0);
      chk("rstp_cnt_out_valid", 32'(cnt_out_valid), 32'd0);
      chk("rstp_keep_out", 32'(keep_out), 32'h00);
      chk("rstp_keep_out_valid", 32'(keep_out_valid), 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      chk("post_rst_cnt_out", 32'(cnt_out), 32'd1);

      // Truncated difference: (20 - 14)[3:0] = 6
      step(1'b0, 1'b0, 8'h00, 1'b1, 4'(16'd20 - 16'd14));
      chk("trunc_keep_comb", 32'(keep_comb), 32'h3F);
      chk("trunc_masked", 32'(~keep_comb & 8'hFF), 32'hC0);

      step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      chk("cnt_q_drained", 32'(cnt_q.size()), 32'd0);
      chk("keep_q_drained", 32'(keep_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keep_cnt_codec.md
# keep_cnt_codec

Byte-enable/byte-count codec for the 64-bit AXI-Stream datapath of the 10GbE transmit checksum logic. One direction converts an 8-bit tkeep mask into the number of valid bytes. The other converts a byte count into an LSB-aligned keep mask. Each direction provides a combinational result for same-cycle use (byte counting, checksum-begin masking) and a registered result with valid and error flags for pipelined consumers.

## Interface

Parameters:
- C_KEEP_WIDTH, 8: keep-mask width in bytes. Only 8 is supported; any other value is a configuration error.
- C_CNT_WIDTH, 4: count width, equal to clog2(C_KEEP_WIDTH+1).

Ports:
- mm2s_clk  in  1  single clock; all registers sample on the rising edge.
- mm2s_reset  in  1  synchronous reset, active-high.
- keep_in_valid  in  1  qualifies keep_in.
- keep_in  in  8  tkeep mask; bit i set means byte i is valid.
- cnt_comb  out  4  combinational count of keep_in, valid regardless of keep_in_valid.
- cnt_out  out  4  registered count.
- cnt_out_valid  out  1  registered keep_in_valid.
- keep_err  out  1  registered flag: keep_in was not LSB-contiguous.
- cnt_in_valid  in  1  qualifies cnt_in.
- cnt_in  in  4  byte count, 0..15.
- keep_comb  out  8  combinational mask of cnt_in.
- keep_out  out  8  registered mask.
- keep_out_valid  out  1  registered cnt_in_valid.
- cnt_ovf  out  1  registered flag: cnt_in > 8.

## Operation

- keep→cnt: cnt_comb = popcount(keep_in), range 0..8. Population count is used, not the position of the highest set bit.
- Contiguity: keep_in is legal when it equals (1<<n)-1 for some n in 0..8. Any other pattern, for example 0x05 or 0x80, raises the error. The count is still the popcount.
- cnt→keep: keep_comb has bits [cnt_in-1:0] set and all others clear.
  - cnt_in = 0 gives 0x00.
  - cnt_in = 8 gives 0xFF.
  - cnt_in 9..15 saturates to 0xFF and raises the overflow.
- Callers may pass a 4-bit truncated difference, such as (byte_count − begin_offset)[3:0]. No sign handling is performed; the value is interpreted as unsigned.
- The two directions are fully independent and may be active in the same cycle.
- The combinational outputs are pure functions of the inputs. They carry no reset and no valid gating.

## Timing

- Latency of the registered path is 1 cycle.
  - keep_in / keep_in_valid sampled at edge N appear on cnt_out / keep_err / cnt_out_valid after edge N.
  - The cnt→keep path behaves the same way.
- Registered data (cnt_out, keep_err, keep_out, cnt_ovf) updates only when the matching input valid is 1 at the edge. Otherwise it holds its last value.
- cnt_out_valid and keep_out_valid are updated every cycle: each is a 1-cycle delayed copy of its input valid.
- There is no backpressure and no handshake. Consumers must accept a result on the cycle its valid is high.
- Reset (synchronous, mm2s_reset = 1 at an edge):
  - cnt_out = 0, keep_err = 0, cnt_out_valid = 0.
  - keep_out = 0x00, cnt_ovf = 0, keep_out_valid = 0.
- Reset has priority over an asserted input valid in the same cycle.
- Reset mid-stream discards any in-flight result. The first valid input after reset is released produces its result 1 cycle later, as normal.
- The combinational outputs are unaffected by reset.

## Test plan

- Exhaustive keep→cnt: sweep keep_in 0x00..0xFF with valid=1.
  - cnt_comb equals popcount in the same cycle; cnt_out equals popcount 1 cycle later.
  - keep_err is 1 for all 247 non-contiguous masks. It is 0 only for 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF.
- Exhaustive cnt→keep: sweep cnt_in 0..15.
  - 0→0x00, 3→0x07, 8→0xFF with cnt_ovf=0.
  - 9..15→0xFF with cnt_ovf=1.
- Hold behaviour: keep_in=0x0F with valid=1, then keep_in=0xFF with valid=0 for 3 cycles.
  - cnt_out stays 4.
  - cnt_out_valid is 1 for one cycle, then 0.
- Concurrent directions: keep_in=0x3F and cnt_in=5, both valid in the same cycle.
  - Next cycle: cnt_out=6, keep_out=0x1F, both valids are 1, no flags raised.
- Reset priority: assert mm2s_reset together with keep_in=0xFF, valid=1.
  - Next cycle: cnt_out=0, cnt_out_valid=0.
  - Release reset with keep_in=0x01, valid=1: one cycle later cnt_out=1.
- Truncated-difference use: cnt_in = (16'd20 − 16'd14)[3:0] = 6.
  - keep_comb = 0x3F, so the inverted mask ANDed with tkeep 0xFF gives 0xC0.
